uart_autobaud_ctrl: RTL

UART_AUTOBAUD_CTRL -- requirements
Module: uart_autobaud_ctrl

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_sync2.sv | 22 ++
 rtl/uart_autobaud_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART auto-baud controller: state encoding and
// default measurement parameters.
package uart_pkg;

  localparam int unsigned OVS_LOG2_DEF = 4;
  localparam int unsigned CNT_W_DEF    = 20;
  localparam int unsigned DIV_W        = 16;
  localparam int unsigned IDLE_RUN     = 16;
  localparam int unsigned SETTLE_SH    = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_IDLE = 3'd1,
    ST_ARMED     = 3'd2,
    ST_MEASURE   = 3'd3,
    ST_SETTLE    = 3'd4,
    ST_LOCKED    = 3'd5,
    ST_ERROR     = 3'd6
  } state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the idle
// (high) level so reset never fabricates a start-bit edge.
module uart_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_autobaud_ctrl.sv
// Auto-baud acquisition: measures the start-bit width of a calibration
// character, derives the baud divisor and locks it once the line settles.
module uart_autobaud_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned OVS_LOG2 = OVS_LOG2_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             rx,
  input  logic             sw_override,
  input  logic [DIV_W-1:0] sw_divisor,
  output logic [DIV_W-1:0] divisor,
  output logic             baud_en,
  output logic             busy,
  output logic             locked,
  output logic             err
);

  localparam int unsigned SET_W  = CNT_W + SETTLE_SH;
  localparam int unsigned WIDE_W = (CNT_W + 1 > DIV_W + 1) ? CNT_W + 1 : DIV_W + 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;
  localparam logic [WIDE_W-1:0] ROUND   = WIDE_W'(1) << (OVS_LOG2 - 1);
  localparam logic [WIDE_W-1:0] DIV_MAX = WIDE_W'({DIV_W{1'b1}});

  state_e            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [CNT_W-1:0]  meas, meas_nxt;
  logic [DIV_W-1:0]  meas_div, meas_div_nxt;
  logic [SET_W-1:0]  set_cnt, set_cnt_nxt;
  logic [SET_W-1:0]  set_target;
  logic [DIV_W-1:0]  div_q, div_nxt;
  logic              locked_nxt, err_nxt, busy_nxt, baud_en_nxt;
  logic              rx_s, rx_d;
  logic              fall, rise;
  logic [WIDE_W-1:0] div_full;
  logic              div_bad;

  uart_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  assign fall       = rx_d & ~rx_s;
  assign rise       = ~rx_d & rx_s;
  assign div_full   = (WIDE_W'(cnt) + ROUND) >> OVS_LOG2;
  assign div_bad    = (div_full == '0) || (div_full > DIV_MAX);
  assign set_target = SET_W'(meas) << SETTLE_SH;
  assign divisor    = sw_override ? sw_divisor : div_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      meas     <= '0;
      meas_div <= '0;
      set_cnt  <= '0;
      div_q    <= '0;
      locked   <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
      baud_en  <= 1'b0;
      rx_d     <= 1'b1;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      meas     <= meas_nxt;
      meas_div <= meas_div_nxt;
      set_cnt  <= set_cnt_nxt;
      div_q    <= div_nxt;
      locked   <= locked_nxt;
      err      <= err_nxt;
      busy     <= busy_nxt;
      baud_en  <= baud_en_nxt;
      rx_d     <= rx_s;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    meas_nxt     = meas;
    meas_div_nxt = meas_div;
    set_cnt_nxt  = set_cnt;
    div_nxt      = div_q;
    locked_nxt   = locked;
    err_nxt      = err;

    case (state)
      ST_WAIT_IDLE: begin
        if (!rx_s) begin
          cnt_nxt = '0;
        end else if (cnt == CNT_W'(IDLE_RUN - 1)) begin
          state_nxt = ST_ARMED;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_ARMED: begin
        if (fall) begin
          state_nxt = ST_MEASURE;
          cnt_nxt   = CNT_W'(1);
        end
      end
      ST_MEASURE: begin
        if (rise) begin
          meas_nxt     = cnt;
          meas_div_nxt = DIV_W'(div_full);
          set_cnt_nxt  = '0;
          if (div_bad) begin
            state_nxt = ST_ERROR;
            err_nxt   = 1'b1;
          end else begin
            state_nxt = ST_SETTLE;
          end
        end else if (!rx_s) begin
          if (cnt == CNT_MAX) begin
            state_nxt = ST_ERROR;
            err_nxt   = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      // Any low on the line restarts the quiet-time wait for the rest of the character.
      ST_SETTLE: begin
        if (!rx_s) begin
          set_cnt_nxt = '0;
        end else if ((set_cnt + SET_W'(1)) >= set_target) begin
          state_nxt  = ST_LOCKED;
          locked_nxt = 1'b1;
          div_nxt    = meas_div;
        end else begin
          set_cnt_nxt = set_cnt + SET_W'(1);
        end
      end
      default: ;
    endcase

    // Abort has priority over start; a locked divisor survives only an abort from LOCKED.
    if (abort) begin
      state_nxt   = ST_IDLE;
      cnt_nxt     = '0;
      set_cnt_nxt = '0;
      if (state != ST_LOCKED) begin
        locked_nxt = 1'b0;
        div_nxt    = '0;
      end
    end else if (start) begin
      state_nxt   = ST_WAIT_IDLE;
      cnt_nxt     = '0;
      set_cnt_nxt = '0;
      err_nxt     = 1'b0;
      locked_nxt  = 1'b0;
      div_nxt     = '0;
    end

    busy_nxt    = (state_nxt == ST_WAIT_IDLE) || (state_nxt == ST_ARMED) ||
                  (state_nxt == ST_MEASURE)   || (state_nxt == ST_SETTLE);
    baud_en_nxt = (sw_override && (sw_divisor != '0)) || locked_nxt;
  end

endmodule
